// File: rtl/lnl_boot_pkg.sv
// Shared types and constants for the SPI boot loader.
package lnl_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [3:0] ROM_WR_BASE  = 4'h8;
    localparam int         ROM_WR_SLOTS = 4;
    localparam logic [7:0] SPI_RD_CMD   = 8'h03;
    localparam logic [4:0] CMD_BITS     = 5'd8;
    localparam logic [4:0] ADDR_BITS    = 5'd16;
    localparam logic [4:0] WORD_BITS    = 5'd16;

    function automatic logic [3:0] rom_slot(input logic [1:0] idx);
        return ROM_WR_BASE + {2'b00, idx};
    endfunction

endpackage

// File: rtl/spi_boot_loader_if.sv
// Flash-pin and boot-ROM write-port bundle of the boot loader.
interface spi_boot_loader_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        rom_cs;
    logic        rom_we;
    logic [3:0]  rom_addr;
    logic [15:0] rom_din;

    modport master (
        output start, spi_miso,
        input  busy, done, spi_cs_n, spi_sclk, spi_mosi, rom_cs, rom_we, rom_addr, rom_din
    );

    modport slave (
        input  start, spi_miso,
        output busy, done, spi_cs_n, spi_sclk, spi_mosi, rom_cs, rom_we, rom_addr, rom_din
    );
endinterface

// File: rtl/spi_bit_engine.sv
// Mode-0 SPI bit engine at clk/2: shifts a left-aligned word out on MOSI and MISO in.
module spi_bit_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [15:0] i_tx,
    input  logic [4:0]  i_nbits,
    input  logic        i_miso,
    output logic        o_sclk,
    output logic        o_mosi,
    output logic        o_bits_done,
    output logic [15:0] o_rx
);
    logic        r_run;
    logic        r_phase;
    logic        r_sclk;
    logic [4:0]  r_cnt;
    logic [15:0] r_tx;
    logic [15:0] r_rx;

    // Phase toggle, shift registers and remaining-bit counter; a load restarts a burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run   <= 1'b0;
            r_phase <= 1'b0;
            r_sclk  <= 1'b0;
            r_cnt   <= 5'd0;
            r_tx    <= 16'h0000;
            r_rx    <= 16'h0000;
        end else if (i_load) begin
            r_run   <= 1'b1;
            r_phase <= 1'b0;
            r_sclk  <= 1'b0;
            r_cnt   <= i_nbits;
            r_tx    <= i_tx;
        end else if (r_run && !r_phase) begin
            r_sclk  <= 1'b1;
            r_phase <= 1'b1;
            r_rx    <= {r_rx[14:0], i_miso};
        end else if (r_run) begin
            r_sclk  <= 1'b0;
            r_phase <= 1'b0;
            r_tx    <= {r_tx[14:0], 1'b0};
            r_cnt   <= r_cnt - 5'd1;
            r_run   <= (r_cnt != 5'd1);
        end
    end

    assign o_sclk      = r_sclk;
    assign o_mosi      = r_tx[15];
    assign o_rx        = r_rx;
    assign o_bits_done = r_run & r_phase & (r_cnt == 5'd1);
endmodule

// File: rtl/spi_boot_loader.sv
// Boot loader: reads NWORDS words from SPI flash in one burst and writes them to ROM slots 0x8 upward.
module spi_boot_loader
    import lnl_boot_pkg::*;
#(
    parameter logic [15:0] FLASH_ADDR = 16'h0000,
    parameter int          NWORDS     = 4,
    parameter logic [7:0]  RD_CMD     = SPI_RD_CMD
)(
    input  logic              clk,
    input  logic              rst,
    spi_boot_loader_if.slave  bus
);
    localparam int         LP_N      = (NWORDS > ROM_WR_SLOTS) ? ROM_WR_SLOTS : NWORDS;
    localparam logic [2:0] LP_NWORDS = 3'(LP_N);

    state_t      r_state;
    logic        r_cs_n;
    logic        r_busy;
    logic        r_done;
    logic        r_rom_cs;
    logic        r_we_arm;
    logic        r_rom_we;
    logic [3:0]  r_rom_addr;
    logic [15:0] r_rom_din;
    logic [2:0]  r_idx;
    logic [1:0]  r_wcnt;

    logic        w_load;
    logic [15:0] w_tx;
    logic [4:0]  w_nbits;
    logic        w_bits_done;
    logic        w_sclk;
    logic        w_mosi;
    logic [15:0] w_rx;
    logic        w_last;

    assign w_last = ((r_idx + 3'd1) == LP_NWORDS);

    spi_bit_engine u_eng (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_tx        (w_tx),
        .i_nbits     (w_nbits),
        .i_miso      (bus.spi_miso),
        .o_sclk      (w_sclk),
        .o_mosi      (w_mosi),
        .o_bits_done (w_bits_done),
        .o_rx        (w_rx)
    );

    // Engine (re)load on the same edge the FSM enters a shifting phase, so no idle cycle is inserted.
    always_comb begin
        w_load  = 1'b0;
        w_tx    = 16'h0000;
        w_nbits = 5'd0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_load  = 1'b1;
                    w_tx    = {RD_CMD, 8'h00};
                    w_nbits = CMD_BITS;
                end else begin
                    w_load  = 1'b0;
                end
            end
            ST_CMD: begin
                if (w_bits_done) begin
                    w_load  = 1'b1;
                    w_tx    = FLASH_ADDR;
                    w_nbits = ADDR_BITS;
                end else begin
                    w_load  = 1'b0;
                end
            end
            ST_ADDR: begin
                if (w_bits_done) begin
                    w_load  = 1'b1;
                    w_nbits = WORD_BITS;
                end else begin
                    w_load  = 1'b0;
                end
            end
            ST_WRITE: begin
                if ((r_wcnt == 2'd2) && !w_last) begin
                    w_load  = 1'b1;
                    w_nbits = WORD_BITS;
                end else begin
                    w_load  = 1'b0;
                end
            end
            default: w_load = 1'b0;
        endcase
    end

    // Load sequencer with registered flash-select, status and ROM write-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rom_cs   <= 1'b0;
            r_we_arm   <= 1'b0;
            r_rom_addr <= 4'h0;
            r_rom_din  <= 16'h0000;
            r_idx      <= 3'd0;
            r_wcnt     <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state <= ST_CMD;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_idx   <= 3'd0;
                    end
                end
                ST_CMD:  if (w_bits_done) r_state <= ST_ADDR;
                ST_ADDR: if (w_bits_done) r_state <= ST_DATA;
                ST_DATA: begin
                    if (w_bits_done) begin
                        r_state    <= ST_WRITE;
                        r_rom_cs   <= 1'b1;
                        r_rom_addr <= rom_slot(r_idx[1:0]);
                        r_rom_din  <= w_rx;
                        r_wcnt     <= 2'd0;
                    end
                end
                ST_WRITE: begin
                    case (r_wcnt)
                        2'd0: begin
                            r_wcnt   <= 2'd1;
                            r_we_arm <= 1'b1;
                        end
                        2'd1: begin
                            r_wcnt   <= 2'd2;
                            r_we_arm <= 1'b0;
                        end
                        default: begin
                            r_rom_cs <= 1'b0;
                            r_idx    <= r_idx + 3'd1;
                            if (w_last) begin
                                r_state <= ST_DONE;
                                r_cs_n  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_DATA;
                            end
                        end
                    endcase
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Write enable launched on the falling edge so it is settled across the ROM's strobing rising edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) r_rom_we <= 1'b0;
        else     r_rom_we <= r_we_arm;
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.spi_cs_n = r_cs_n;
    assign bus.spi_sclk = w_sclk;
    assign bus.spi_mosi = w_mosi;
    assign bus.rom_cs   = r_rom_cs;
    assign bus.rom_we   = r_rom_we;
    assign bus.rom_addr = r_rom_addr;
    assign bus.rom_din  = r_rom_din;
endmodule

// File: tb/tb_spi_boot_loader.sv
// Directed bench for spi_boot_loader: SPI flash model, gated-strobe ROM model and write scoreboard.
module tb_spi_boot_loader;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] din;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   c0_a = 0;
    int   c0_b = 0;

    logic [15:0] fmem [256];
    wr_t         sb_a [$];
    wr_t         sb_b [$];

    spi_boot_loader_if bus_a ();
    spi_boot_loader_if bus_b ();

    spi_boot_loader #(.FLASH_ADDR(16'h0000), .NWORDS(4), .RD_CMD(8'h03)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    spi_boot_loader #(.FLASH_ADDR(16'h0100), .NWORDS(1), .RD_CMD(8'h03)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- flash models (mode 0, continuous read burst) ----------------
    logic [4:0]  fa_cnt = 5'd0, fb_cnt = 5'd0;
    logic [23:0] fa_sh = 24'd0, fb_sh = 24'd0;
    logic        fa_strm = 1'b0, fb_strm = 1'b0;
    logic [7:0]  fa_wa = 8'd0, fb_wa = 8'd0;
    logic [3:0]  fa_bp = 4'd0, fb_bp = 4'd0;

    always @(posedge bus_a.spi_sclk or posedge bus_a.spi_cs_n)
        if (bus_a.spi_cs_n) fa_cnt <= 5'd0;
        else if (fa_cnt < 5'd24) begin
            fa_sh  <= {fa_sh[22:0], bus_a.spi_mosi};
            fa_cnt <= fa_cnt + 5'd1;
        end

    always @(negedge bus_a.spi_sclk or posedge bus_a.spi_cs_n)
        if (bus_a.spi_cs_n) begin
            fa_strm <= 1'b0;
            bus_a.spi_miso <= 1'b0;
        end else if (fa_cnt == 5'd24) begin
            if (!fa_strm) begin
                fa_strm <= 1'b1;
                fa_wa <= fa_sh[8:1];
                fa_bp <= 4'd15;
                bus_a.spi_miso <= fmem[fa_sh[8:1]][15];
            end else if (fa_bp == 4'd0) begin
                fa_wa <= fa_wa + 8'd1;
                fa_bp <= 4'd15;
                bus_a.spi_miso <= fmem[fa_wa + 8'd1][15];
            end else begin
                fa_bp <= fa_bp - 4'd1;
                bus_a.spi_miso <= fmem[fa_wa][fa_bp - 4'd1];
            end
        end

    always @(posedge bus_b.spi_sclk or posedge bus_b.spi_cs_n)
        if (bus_b.spi_cs_n) fb_cnt <= 5'd0;
        else if (fb_cnt < 5'd24) begin
            fb_sh  <= {fb_sh[22:0], bus_b.spi_mosi};
            fb_cnt <= fb_cnt + 5'd1;
        end

    always @(negedge bus_b.spi_sclk or posedge bus_b.spi_cs_n)
        if (bus_b.spi_cs_n) begin
            fb_strm <= 1'b0;
            bus_b.spi_miso <= 1'b0;
        end else if (fb_cnt == 5'd24) begin
            if (!fb_strm) begin
                fb_strm <= 1'b1;
                fb_wa <= fb_sh[8:1];
                fb_bp <= 4'd15;
                bus_b.spi_miso <= fmem[fb_sh[8:1]][15];
            end else if (fb_bp == 4'd0) begin
                fb_wa <= fb_wa + 8'd1;
                fb_bp <= 4'd15;
                bus_b.spi_miso <= fmem[fb_wa + 8'd1][15];
            end else begin
                fb_bp <= fb_bp - 4'd1;
                bus_b.spi_miso <= fmem[fb_wa][fb_bp - 4'd1];
            end
        end

    // ---------------- ROM models clocked by the gated strobe ----------------
    wire w_stb_a = bus_a.rom_cs & bus_a.rom_we & clk;
    wire w_stb_b = bus_b.rom_cs & bus_b.rom_we & clk;
    logic [15:0] rom_a [16] = '{default: 16'h0000};
    logic [15:0] rom_b [16] = '{default: 16'h0000};
    int          wcnt_a [16] = '{default: 0};
    int          sa_cnt = 0, sb_cnt = 0;
    int          stb_cyc_a [64] = '{default: 0};
    logic [3:0]  sa_addr = 4'h0, sb_addr = 4'h0;
    logic [15:0] sa_din = 16'h0, sb_din = 16'h0;

    always @(posedge w_stb_a) begin
        stb_cyc_a[sa_cnt & 63] <= cyc - c0_a;
        sa_cnt  <= sa_cnt + 1;
        sa_addr <= bus_a.rom_addr;
        sa_din  <= bus_a.rom_din;
        rom_a[bus_a.rom_addr]  <= bus_a.rom_din;
        wcnt_a[bus_a.rom_addr] <= wcnt_a[bus_a.rom_addr] + 1;
        chk("sb_a_pending", 32'(sb_a.size() > 0), 32'd1);
        if (sb_a.size() > 0) begin
            chk("wr_a_addr", 32'(bus_a.rom_addr), 32'(sb_a[0].addr));
            chk("wr_a_din", 32'(bus_a.rom_din), 32'(sb_a[0].din));
            void'(sb_a.pop_front());
        end
    end

    always @(negedge w_stb_a) begin
        chk("stb_a_addr_stable", 32'(bus_a.rom_addr), 32'(sa_addr));
        chk("stb_a_din_stable", 32'(bus_a.rom_din), 32'(sa_din));
    end

    always @(posedge w_stb_b) begin
        sb_cnt  <= sb_cnt + 1;
        sb_addr <= bus_b.rom_addr;
        sb_din  <= bus_b.rom_din;
        rom_b[bus_b.rom_addr] <= bus_b.rom_din;
        chk("sb_b_pending", 32'(sb_b.size() > 0), 32'd1);
        if (sb_b.size() > 0) begin
            chk("wr_b_addr", 32'(bus_b.rom_addr), 32'(sb_b[0].addr));
            chk("wr_b_din", 32'(bus_b.rom_din), 32'(sb_b[0].din));
            void'(sb_b.pop_front());
        end
    end

    always @(negedge w_stb_b) begin
        chk("stb_b_addr_stable", 32'(bus_b.rom_addr), 32'(sb_addr));
        chk("stb_b_din_stable", 32'(bus_b.rom_din), 32'(sb_din));
    end

    // rom_we must never be high without rom_cs
    always begin
        @(clk);
        #1;
        chk("we_without_cs_a", 32'(bus_a.rom_we & ~bus_a.rom_cs), 32'd0);
        chk("we_without_cs_b", 32'(bus_b.rom_we & ~bus_b.rom_cs), 32'd0);
    end

    // ---------------- helpers ----------------
    task automatic push_a();
        wr_t e;
        for (int i = 0; i < 4; i++) begin
            e.addr = 4'h8 + 4'(i);
            e.din  = fmem[i];
            sb_a.push_back(e);
        end
    endtask

    task automatic start_a();
        @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        c0_a = cyc;
        chk("a_busy_after_start", 32'(bus_a.busy), 32'd1);
        chk("a_done_after_start", 32'(bus_a.done), 32'd0);
        chk("a_cs_n_after_start", 32'(bus_a.spi_cs_n), 32'd0);
    endtask

    task automatic wait_done_a(output int k);
        k = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus_a.done) begin
                k = cyc - c0_a;
                break;
            end
        end
    endtask

    task automatic check_rom_a();
        for (int i = 0; i < 4; i++) chk("rom_a_slot", 32'(rom_a[8 + i]), 32'(fmem[i]));
        chk("a_cmd_on_mosi", 32'(fa_sh[23:16]), 32'h03);
        chk("a_addr_on_mosi", 32'(fa_sh[15:0]), 32'h0000);
        chk("sb_a_drained", 32'(sb_a.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int base;
        int w8;
        int w9;
        wr_t e;
        for (int i = 0; i < 256; i++) fmem[i] = 16'h0000;
        fmem[0] = 16'h1234;
        fmem[1] = 16'hABCD;
        fmem[2] = 16'h0F0F;
        fmem[3] = 16'h8001;
        fmem[8'h80] = 16'hC3A5;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_cs_n", 32'(bus_a.spi_cs_n), 32'd1);
        chk("rst_sclk", 32'(bus_a.spi_sclk), 32'd0);
        chk("rst_mosi", 32'(bus_a.spi_mosi), 32'd0);
        chk("rst_rom_cs", 32'(bus_a.rom_cs), 32'd0);
        chk("rst_rom_we", 32'(bus_a.rom_we), 32'd0);
        chk("rst_rom_addr", 32'(bus_a.rom_addr), 32'd0);
        chk("rst_rom_din", 32'(bus_a.rom_din), 32'd0);
        chk("rst_busy", 32'(bus_a.busy), 32'd0);
        chk("rst_done", 32'(bus_a.done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // full default load
        base = sa_cnt;
        push_a();
        start_a();
        wait_done_a(k);
        chk("a_done_cycle", 32'(k), 32'd188);
        chk("a_strobe_count", 32'(sa_cnt - base), 32'd4);
        chk("a_first_we_cycle", 32'(stb_cyc_a[base & 63]), 32'd81);
        chk("a_busy_at_done", 32'(bus_a.busy), 32'd0);
        chk("a_cs_n_at_done", 32'(bus_a.spi_cs_n), 32'd1);
        check_rom_a();
        repeat (3) @(negedge clk);

        // restart from DONE with a stray start at cycle 50
        base = sa_cnt;
        push_a();
        start_a();
        repeat (50) @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        wait_done_a(k);
        chk("a2_done_cycle", 32'(k), 32'd188);
        chk("a2_strobe_count", 32'(sa_cnt - base), 32'd4);
        chk("a2_first_we_cycle", 32'(stb_cyc_a[base & 63]), 32'd81);
        check_rom_a();
        repeat (3) @(negedge clk);

        // reset inside the second write's rom_we window
        base = sa_cnt;
        w8 = wcnt_a[8];
        w9 = wcnt_a[9];
        push_a();
        start_a();
        repeat (116) @(negedge clk);
        #2;
        chk("a_in_we_window", 32'(bus_a.rom_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_rom_we", 32'(bus_a.rom_we), 32'd0);
        chk("abort_rom_cs", 32'(bus_a.rom_cs), 32'd0);
        chk("abort_cs_n", 32'(bus_a.spi_cs_n), 32'd1);
        chk("abort_busy", 32'(bus_a.busy), 32'd0);
        chk("abort_done", 32'(bus_a.done), 32'd0);
        chk("abort_strobes", 32'(sa_cnt - base), 32'd1);
        chk("abort_slot8_writes", 32'(wcnt_a[8] - w8), 32'd1);
        chk("abort_slot9_writes", 32'(wcnt_a[9] - w9), 32'd0);
        chk("abort_sb_left", 32'(sb_a.size()), 32'd3);
        sb_a.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base = sa_cnt;
        push_a();
        start_a();
        wait_done_a(k);
        chk("a3_done_cycle", 32'(k), 32'd188);
        chk("a3_strobe_count", 32'(sa_cnt - base), 32'd4);
        check_rom_a();

        // single word from byte address 0x0100
        e.addr = 4'h8;
        e.din  = fmem[8'h80];
        sb_b.push_back(e);
        @(negedge clk);
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        c0_b = cyc;
        k = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_b.done) begin
                k = cyc - c0_b;
                break;
            end
        end
        chk("b_done_cycle", 32'(k), 32'd83);
        chk("b_strobe_count", 32'(sb_cnt), 32'd1);
        chk("b_cmd_on_mosi", 32'(fb_sh[23:16]), 32'h03);
        chk("b_addr_on_mosi", 32'(fb_sh[15:0]), 32'h0100);
        chk("b_slot8", 32'(rom_b[8]), 32'hC3A5);
        for (int i = 9; i < 12; i++) chk("b_slot_untouched", 32'(rom_b[i]), 32'h0000);
        chk("sb_b_drained", 32'(sb_b.size()), 32'd0);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_boot_loader.md
# spi_boot_loader

Boot-time loader for the writable upper bank of the boot ROM. On `start` it reads `NWORDS` 16-bit words from an external SPI flash using a standard 0x03 read command. Each word is written into boot-ROM slots 0x8 upward through the ROM's `cs`/`we`/`addr`/`din` write port. It sits between the SPI flash pins and the boot ROM, and holds the CPU off (`busy`) until the bank is populated.

## Interface
- `FLASH_ADDR`, 16'h0000: flash byte address of the first word.
- `NWORDS`, 4: words to load; legal range 1..4, never wraps past ROM slot 0xB.
- `RD_CMD`, 8'h03: SPI read opcode.
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level-sampled load request, honoured only in IDLE or DONE.
- `busy` out 1: high from the start-sampling edge until the last write completes.
- `done` out 1: high after a completed load, until the next `start` or `rst`.
- `spi_cs_n` out 1: flash chip select, active low.
- `spi_sclk` out 1: SPI clock, mode 0, clk/2.
- `spi_mosi` out 1: command/address bits, MSB first.
- `spi_miso` in 1: flash data, MSB first.
- `rom_cs` out 1: boot-ROM chip select.
- `rom_we` out 1: boot-ROM write enable.
- `rom_addr` out 4: boot-ROM slot, 0x8 + word index.
- `rom_din` out 16: word to write.

## Operation
- States: IDLE, CMD, ADDR, DATA, WRITE, DONE.
- **IDLE or DONE + `start`** → CMD. Same edge: `spi_cs_n` = 0, `busy` = 1, `done` = 0, word index = 0.
- **Bit engine.** Each SPI bit takes 2 clk cycles.
  - Phase 0: `spi_sclk` = 0; `spi_mosi` holds the current bit.
  - At the edge ending phase 0, `spi_sclk` goes 1 and `spi_miso` is sampled into a 16-bit shift register.
  - Phase 1: `spi_sclk` = 1.
- **CMD:** 8 bits of `RD_CMD`, then → ADDR.
- **ADDR:** 16 bits of `FLASH_ADDR`, then → DATA.
  - `spi_mosi` = 0 from DATA onward.
- **DATA:** 16 bits shifted in; first received bit becomes bit 15. Then → WRITE, with `spi_sclk` parked at 0.
- **WRITE:** 3 cycles; flash stays selected, no SCLK pulses.
  - Cycle 1: `rom_addr` = 0x8 + index and `rom_din` = shifted word driven and held; `rom_cs` = 1.
  - Cycle 2 (`rom_we` window): `rom_we` = 1 for one full clk period. It is produced by a negedge-clk flop, so it is stable across the posedge that clocks the ROM's gated write strobe (`cs & we & clk`). No glitch on the gated strobe is allowed.
  - Cycle 3: `rom_we` = 0; `rom_cs` = 0 at the end of the cycle.
  - `rom_addr`/`rom_din` stay unchanged through all 3 cycles.
  - Index increments. If index == `NWORDS` → DONE, else → DATA. Flash is read as one continuous burst with no re-addressing.
- **DONE:** `spi_cs_n` = 1, `busy` = 0, `done` = 1.
- `start` while busy is ignored.
- `rom_cs`/`rom_we` are never high outside WRITE.
- `rom_we` is never high while `rom_cs` is low.
- `rom_addr` never addresses slots 0x0–0x7.

## Timing
- Reset values:
  - `spi_cs_n` = 1
  - `spi_sclk` = 0, `spi_mosi` = 0
  - `rom_cs` = 0, `rom_we` = 0, `rom_addr` = 0, `rom_din` = 0
  - `busy` = 0, `done` = 0
  - State IDLE.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous).
  - A write in progress is aborted; `rom_we` drops with `rst`.
  - Flash is deselected; no partial word is written.
- Cycle budget:
  - CMD+ADDR: 48 cycles.
  - Each word: 32 DATA + 3 WRITE cycles.
- With defaults, `done` rises 48 + 4·35 = 188 cycles after the start-sampling edge.
- The first `rom_we` high window begins 48 + 32 + 1 = 81 cycles after the start-sampling edge.

## Structure
- Package `lnl_boot_pkg`:
  - state enum
  - `ROM_WR_BASE` = 4'h8
  - `ROM_WR_SLOTS` = 4
  - `SPI_RD_CMD` = 8'h03
  - bit-count constants CMD = 8, ADDR = 16, WORD = 16
- One sub-module, `spi_bit_engine`:
  - clk/2 phase toggle
  - MOSI shift-out and MISO shift-in
  - bit counter with a `bits_done` pulse
- The FSM and ROM write sequencing live in `spi_boot_loader`.

## Test plan
- Flash model preloaded 0x1234, 0xABCD, 0x0F0F, 0x8001 at 0x0000. Pulse `start` → MOSI carries 0x03 then 0x0000. ROM slots 8–B read back those four words. `done` = 1 at cycle 188.
- Gated-strobe check at every write: `rom_cs & rom_we & clk` produces exactly one rising edge, with `rom_addr`/`rom_din` stable across it. Four edges total, addresses 8, 9, A, B.
- `NWORDS` = 1, `FLASH_ADDR` = 0x0100 → address bits 0x0100 on MOSI. Only slot 8 written; `done` at cycle 83. Slots 9–B keep 0x0000.
- Assert `rst` during the second WRITE's `rom_we` window → `rom_we` drops immediately, `spi_cs_n` = 1, `busy` = 0, `done` = 0. Restart completes normally.
- Pulse `start` at cycle 50 while busy → ignored, sequence unchanged. `start` after DONE → `done` clears and the load repeats.
